input_buffer: RTL

AXI4-Stream slave that receives 32-bit beats from the host DMA, packs each group of four beats into one 128-bit word, and queues the words in a small first-word-fall-through FIFO. The systolic array's load side reads the words from that FIFO. It is the ingress counterpart of the 128-to-32 output serializer. Its lane order matches that serializer, so a word that makes a round trip through both blocks is preserved bit-for-bit.

---
 rtl/input_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/input_buffer.sv
// Packs 32-bit AXI4-S beats (lane 0 first) into 128-bit words in a FWFT FIFO; word visible the cycle after its closing beat.
// Backpressure: s_axis_ready is registered state only (ready_en && not full); a pop re-opens it after that edge.
module input_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst_n,
  input  logic                     s_axis_valid,
  input  logic [31:0]              s_axis_data,
  input  logic                     s_axis_last,
  output logic                     s_axis_ready,
  output logic                     read_valid,
  output logic [127:0]             read_data,
  output logic                     read_partial,
  input  logic                     read_en,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              r_ready_en;
  logic [1:0]        r_lane;
  logic [95:0]       r_asm;
  logic [127:0]      r_mem  [DEPTH];
  logic              r_part [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_accept;
  logic              w_close;
  logic              w_pop;
  logic [127:0]      w_word;

  assign s_axis_ready = r_ready_en && (r_count != FULL_CNT);
  assign w_accept     = s_axis_valid && s_axis_ready;
  assign w_close      = w_accept && ((r_lane == 2'd3) || s_axis_last);
  assign w_pop        = read_en && (r_count != '0);

  assign read_valid   = (r_count != '0);
  assign read_data    = r_mem[r_rptr];
  assign read_partial = r_part[r_rptr];
  assign word_count   = r_count;

  // Closing beat goes into its own lane; lanes above it are zero-padded.
  always_comb begin
    w_word = '0;
    case (r_lane)
      2'd0:    w_word = {96'b0, s_axis_data};
      2'd1:    w_word = {64'b0, s_axis_data, r_asm[31:0]};
      2'd2:    w_word = {32'b0, s_axis_data, r_asm[63:0]};
      default: w_word = {s_axis_data, r_asm};
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_ready_en <= 1'b0;
      r_lane     <= 2'd0;
      r_asm      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_part[i] <= 1'b0;
      end
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        if (w_close) begin
          r_mem[r_wptr]  <= w_word;
          r_part[r_wptr] <= (r_lane != 2'd3);
          r_wptr         <= r_wptr + 1'b1;
          r_lane         <= 2'd0;
        end else begin
          r_lane <= r_lane + 1'b1;
          case (r_lane)
            2'd0:    r_asm[31:0]  <= s_axis_data;
            2'd1:    r_asm[63:32] <= s_axis_data;
            default: r_asm[95:64] <= s_axis_data;
          endcase
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_close && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_close && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
